// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with frame-based debounce, a four-digit entry shift register
// and a valid/ack handoff of the typed word to the CPU.
module keypad_scanner #(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    input  logic        enter,
    input  logic        data_ack,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] entry_value,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        overrun
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DF       = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    logic [3:0]       row_s1, row_s2;
    logic             en_s1, en_s2, en_s3;
    logic             en_rise;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic             slot_end, frame_end;
    logic [1:0]       frame_hits;
    logic [3:0]       frame_key;
    logic [2:0]       slot_hits;
    logic [1:0]       slot_row;
    logic [2:0]       hit_sum;
    logic [1:0]       hits_sat;
    logic [3:0]       fkey;
    state_t           state, state_next;
    logic [3:0]       cand, cand_next;
    logic [3:0]       cnt, cnt_next;
    logic [3:0]       cnt_inc;
    logic             accept;
    logic [15:0]      entry_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
            en_s1  <= 1'b0;
            en_s2  <= 1'b0;
            en_s3  <= 1'b0;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
            en_s1  <= enter;
            en_s2  <= en_s1;
            en_s3  <= en_s2;
        end
    end

    assign en_rise   = en_s2 & ~en_s3;
    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (col_idx == 2'd3);
    assign col_n     = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
        end else if (slot_end) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Rows are sampled late in the slot so the two-cycle synchroniser has settled
    // on the column currently being driven; the lowest low row names the slot key.
    always_comb begin
        slot_hits = {2'b00, ~row_s2[0]} + {2'b00, ~row_s2[1]}
                  + {2'b00, ~row_s2[2]} + {2'b00, ~row_s2[3]};
        slot_row  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s2[i]) slot_row = 2'(i);
        end
        hit_sum  = {1'b0, frame_hits} + slot_hits;
        hits_sat = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        fkey     = (frame_hits == 2'd0) ? {slot_row, col_idx} : frame_key;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_hits <= 2'd0;
            frame_key  <= 4'h0;
        end else if (frame_end) begin
            frame_hits <= 2'd0;
        end else if (slot_end) begin
            frame_hits <= hits_sat;
            if (frame_hits == 2'd0 && slot_hits != 3'd0) frame_key <= {slot_row, col_idx};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cand  <= 4'h0;
            cnt   <= 4'h0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            cnt   <= cnt_next;
        end
    end

    assign cnt_inc = cnt + 4'd1;

    // MULTI frames count as "no key" while pressing, but keep a held key held.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        accept     = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (hit_sum == 3'd1) begin
                        cand_next = fkey;
                        cnt_next  = 4'd1;
                        if (DF == 4'd1) begin
                            accept     = 1'b1;
                            state_next = HELD;
                        end else begin
                            state_next = PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (hit_sum == 3'd1 && fkey == cand) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == DF) begin
                            accept     = 1'b1;
                            state_next = HELD;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                HELD: begin
                    if (hit_sum == 3'd0) begin
                        cnt_next   = 4'd1;
                        state_next = (DF == 4'd1) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (hit_sum == 3'd0) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == DF) state_next = IDLE;
                    end else begin
                        state_next = HELD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign entry_acc = accept ? {entry_value[11:0], fkey} : entry_value;

    // An enter edge captures the entry including any digit accepted on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_valid   <= 1'b0;
            key_code    <= 4'h0;
            entry_value <= 16'h0000;
            data_out    <= 16'h0000;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            key_valid <= accept;
            overrun   <= 1'b0;
            if (accept) key_code <= fkey;
            if (en_rise && (!data_valid || data_ack)) begin
                data_out    <= entry_acc;
                data_valid  <= 1'b1;
                entry_value <= 16'h0000;
            end else begin
                entry_value <= entry_acc;
                if (en_rise) overrun <= 1'b1;
                else if (data_ack) data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from the column
// pattern, and a negedge monitor pops expected keys, words and overruns.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        enter;
    logic        data_ack;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry_value;
    logic [15:0] data_out;
    logic        data_valid;
    logic        overrun;

    logic [15:0] pressed;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] entry;
    } key_exp_t;

    key_exp_t    exp_keys[$];
    logic [15:0] exp_words[$];
    logic [15:0] exp_ovr[$];

    int n_tests = 0;
    int n_fail  = 0;
    int key_pulses = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] prev_out = 16'h0000;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .enter(enter),
        .data_ack(data_ack), .key_valid(key_valid), .key_code(key_code),
        .entry_value(entry_value), .data_out(data_out), .data_valid(data_valid),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_n[c] && pressed[r*4+c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [15:0] mask, input int on_frames, input int off_frames);
        pressed = mask;
        tick(on_frames * 16);
        pressed = 16'h0000;
        tick(off_frames * 16);
    endtask

    task automatic pulse_enter(input bit with_ack, input bit check_latency);
        enter = 1'b1;
        tick(2);
        if (check_latency) check_output("valid_before_3cyc", {31'b0, data_valid}, 32'd0);
        if (with_ack) data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        if (check_latency) check_output("valid_at_3cyc", {31'b0, data_valid}, 32'd1);
        tick(2);
        enter = 1'b0;
        tick(4);
    endtask

    task automatic ack_once();
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        tick(2);
    endtask

    // Monitor: every DUT-presented event must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
            prev_out   = 16'h0000;
        end else begin
            if (key_valid) begin
                key_pulses++;
                if (exp_keys.size() == 0) begin
                    check_output("unexpected_key_valid", {31'b0, key_valid}, 32'd0);
                end else begin
                    key_exp_t e;
                    e = exp_keys.pop_front();
                    check_output("key_code", {28'b0, key_code}, {28'b0, e.code});
                    check_output("entry_on_key", {16'b0, entry_value}, {16'b0, e.entry});
                end
            end
            if (data_valid && (!prev_valid || data_out != prev_out)) begin
                if (exp_words.size() == 0) check_output("unexpected_load", {31'b0, data_valid}, 32'd0);
                else check_output("data_out_load", {16'b0, data_out}, {16'b0, exp_words.pop_front()});
            end
            if (overrun) begin
                if (exp_ovr.size() == 0) check_output("unexpected_overrun", {31'b0, overrun}, 32'd0);
                else check_output("data_out_on_overrun", {16'b0, data_out}, {16'b0, exp_ovr.pop_front()});
            end
            prev_valid = data_valid;
            prev_out   = data_out;
        end
    end

    initial begin
        logic [3:0]  key_tab   [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        logic [15:0] entry_tab [5] = '{16'h0091, 16'h0912, 16'h9123, 16'h1234, 16'h2345};
        int base;

        rst = 1'b0;
        enter = 1'b0;
        data_ack = 1'b0;
        pressed = 16'h0000;
        tick(3);
        check_output("rst_col_n", {28'b0, col_n}, 32'hE);
        check_output("rst_outputs", {key_valid, key_code, entry_value, data_out, data_valid, overrun},
                     32'h0);

        // Column walk after reset release.
        rst = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            logic [3:0] exp_col;
            tick(1);
            exp_col = ~(4'b0001 << ((n / 4) % 4));
            check_output("col_walk", {28'b0, col_n}, {28'b0, exp_col});
        end

        // Single long press of key 9 gives exactly one pulse.
        base = key_pulses;
        exp_keys.push_back('{4'h9, 16'h0009});
        apply_stimulus(16'h1 << 9, 15, 5);
        check_output("key9_pulses", key_pulses - base, 32'd1);
        check_output("key9_code", {28'b0, key_code}, 32'h9);
        check_output("key9_entry", {16'b0, entry_value}, 32'h0009);

        // Bounce: on 2, off 1, on 2 frames never reaches three stable frames.
        base = key_pulses;
        apply_stimulus(16'h1 << 9, 2, 1);
        apply_stimulus(16'h1 << 9, 2, 5);
        check_output("bounce_pulses", key_pulses - base, 32'd0);

        for (int i = 0; i < 5; i++) begin
            exp_keys.push_back('{key_tab[i], entry_tab[i]});
            apply_stimulus(16'h1 << key_tab[i], 5, 5);
        end
        check_output("entry_2345", {16'b0, entry_value}, 32'h2345);

        exp_words.push_back(16'h2345);
        pulse_enter(1'b0, 1'b1);
        check_output("entry_cleared", {16'b0, entry_value}, 32'h0);
        check_output("data_out_2345", {16'b0, data_out}, 32'h2345);

        ack_once();
        check_output("valid_after_ack", {31'b0, data_valid}, 32'd0);
        check_output("data_out_held", {16'b0, data_out}, 32'h2345);

        exp_words.push_back(16'h0000);
        pulse_enter(1'b0, 1'b1);

        exp_keys.push_back('{4'hA, 16'h000A});
        apply_stimulus(16'h1 << 10, 5, 5);

        exp_ovr.push_back(16'h0000);
        pulse_enter(1'b0, 1'b0);
        check_output("ovr_data_out", {16'b0, data_out}, 32'h0);
        check_output("ovr_entry", {16'b0, entry_value}, 32'h000A);

        exp_words.push_back(16'h000A);
        pulse_enter(1'b1, 1'b0);
        check_output("same_cycle_valid", {31'b0, data_valid}, 32'd1);
        check_output("same_cycle_data", {16'b0, data_out}, 32'h000A);
        ack_once();

        // Two keys together never settle as a single key.
        base = key_pulses;
        apply_stimulus(16'h0021, 6, 6);
        check_output("multi_pulses", key_pulses - base, 32'd0);

        // Reset while key 7 sits in the press debounce.
        pressed = 16'h1 << 7;
        tick(32);
        rst = 1'b0;
        #1;
        check_output("midrst_col_n", {28'b0, col_n}, 32'hE);
        check_output("midrst_outputs", {key_valid, key_code, entry_value, data_out, data_valid, overrun},
                     32'h0);
        tick(2);
        exp_keys.push_back('{4'h7, 16'h0007});
        base = key_pulses;
        rst = 1'b1;
        tick(40);
        check_output("post_rst_early", key_pulses - base, 32'd0);
        for (int t = 0; t < 30 && key_pulses == base; t++) tick(1);
        check_output("post_rst_key7", key_pulses - base, 32'd1);
        pressed = 16'h0000;
        tick(80);

        check_output("keys_left", exp_keys.size(), 32'd0);
        check_output("words_left", exp_words.size(), 32'd0);
        check_output("ovr_left", exp_ovr.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
